slot_io_target: RTL and testbench
=================================

Name: slot_io_target

Overview:
Slot-side I/O responder for a dock peripheral slot. It sits on one slot's chip select from the dock address decoder and answers the decoded I/O cycle. Reads and writes go to a small local register file. It stretches the cycle with programmable wait states through dev_ready_n, and drives the slot data bus on reads. It exposes the register contents to slot logic.

Parameters:
IDX_W, 2, register index width; uses the low IDX_W bits of addr.
NUM_REGS, 4, number of 8-bit registers; must be at most 2**IDX_W.
DATA_W, 8, data bus width.
WAIT_W, 4, width of the wait-state count.

Ports:
clk  in  1  slot clock, same clock as the decoder.
rst  in  1  asynchronous, active-high reset.
cs_n  in  1  slot chip select from the decoder, active low.
io_r_w_  in  1  1 = read, 0 = write; valid while cs_n is low.
addr  in  IDX_W  register index; valid while cs_n is low.
data_in  in  DATA_W  write data from the host bus.
data_out  out  DATA_W  read data to the host bus.
data_oe  out  1  slot data driver enable, active high.
dev_ready_n  out  1  0 = insert wait state; 1 = ready.
wait_states  in  WAIT_W  extra cycles per access, sampled at cycle start.
regs_flat  out  NUM_REGS*DATA_W  register contents; register i is at [i*DATA_W +: DATA_W].

Behaviour:
- Reset (async, rst=1):
  - All registers = 0, FSM = IDLE, wait counter = 0.
  - data_out = 0, data_oe = 0, dev_ready_n = 1.
- FSM states: IDLE, WAIT, ACK, HOLD.
- IDLE:
  - dev_ready_n = ~(~cs_n & (wait_states != 0)). This is combinational, so the decoder sees "not ready" on its first ACTIVE edge.
  - At a clk edge with cs_n=0: latch addr, io_r_w_ and wait_states into cnt.
  - Go to WAIT if cnt != 0, else go to ACK.
- WAIT:
  - dev_ready_n = 0.
  - cnt decrements each edge; go to ACK when cnt reaches 1.
  - With N wait states, dev_ready_n is low for exactly N clk cycles after cs_n falls.
- ACK:
  - dev_ready_n = 1 for exactly one cycle.
  - Write: on the exit edge, reg[idx] <= data_in. This happens exactly once per cycle.
  - Read: data_out is already valid (loaded from reg[idx] on entry).
  - Next state is HOLD.
- HOLD:
  - dev_ready_n = 1.
  - data_out holds its value; no further writes.
  - Go to IDLE at the first edge with cs_n=1.
- data_oe = ~cs_n & latched read, in the WAIT, ACK and HOLD states. It deasserts combinationally when cs_n rises.
- data_out: on reads it is loaded from reg[idx] on WAIT or ACK entry. It holds its last value otherwise.
- Out-of-range index (idx >= NUM_REGS):
  - Reads return 0.
  - Writes are dropped.
  - The handshake completes normally.
- cs_n rises before ACK (aborted cycle):
  - Return to IDLE at that edge.
  - No write is committed; dev_ready_n = 1.
- cs_n low again on the edge after HOLD→IDLE: this is treated as a new cycle.
- addr, io_r_w_ and data_in changing after the cycle start are ignored for index and direction. data_in is sampled at ACK exit.
- rst asserted mid-cycle: immediate return to IDLE with reset values; the pending write is lost.

Optional Feature:
Macro: SLOT_IRQ_EN.
- Defined:
  - Adds input irq_set (1) and output irq_n (1, reset 1).
  - The sticky pending bit sets on irq_set=1.
  - Register NUM_REGS-1 becomes IRQ control: bit0 = pending (read), bit1 = enable (read/write).
  - Writing a value with bit0=1 clears pending. If set and clear occur on the same edge, set wins.
  - irq_n = ~(pending & enable), registered.
- Not defined:
  - The ports are absent.
  - Register NUM_REGS-1 is a plain read/write register.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → dev_ready_n=1, data_oe=0, regs_flat=0, data_out=0.
- Zero-wait write then read: wait_states=0; write addr=2, data_in=8'hA5 → dev_ready_n never low, reg2=A5. Read addr=2 → data_out=A5 and data_oe=1 while cs_n=0.
- Wait-state stretch: wait_states=3; read addr=1 (reg1=5A) → dev_ready_n=0 for exactly 3 cycles from cs_n fall, then 1; data_out=5A.
- Abort: wait_states=4; write addr=0, data_in=FF; raise cs_n after 2 cycles → reg0 unchanged, FSM IDLE, dev_ready_n=1.
- Out-of-range and reset mid-cycle: NUM_REGS=3; read addr=3 → data_out=00 with a normal handshake. Assert rst during WAIT → all outputs return to reset values at once.
- SLOT_IRQ_EN: pulse irq_set; write reg3=8'h02 → irq_n=0. Write reg3=8'h03 → irq_n=1, pending reads 0. Set and clear on the same edge → pending stays 1.

Source files
------------

// File: rtl/slot_io_target.sv
// slot_io_target: slot-side I/O responder for one dock peripheral slot.
// Answers decoded I/O cycles from a small local register file, stretches
// the cycle with programmable wait states on dev_ready_n, and exposes the
// register contents to slot logic through regs_flat.
// Optional build macro SLOT_IRQ_EN: adds irq_set/irq_n and turns register
// NUM_REGS-1 into the IRQ control register (bit0 pending, bit1 enable).
module slot_io_target #(
  parameter int IDX_W    = 2,
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 8,
  parameter int WAIT_W   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cs_n,
  input  logic                         io_r_w_,
  input  logic [IDX_W-1:0]             addr,
  input  logic [DATA_W-1:0]            data_in,
  output logic [DATA_W-1:0]            data_out,
  output logic                         data_oe,
  output logic                         dev_ready_n,
  input  logic [WAIT_W-1:0]            wait_states,
`ifdef SLOT_IRQ_EN
  input  logic                         irq_set,
  output logic                         irq_n,
`endif
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat
);

  localparam int NUM_IDX = 1 << IDX_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [1:0]        state_reg;
  logic [WAIT_W-1:0] cnt_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              rd_reg;
  logic [DATA_W-1:0] data_out_reg;
  logic              wr_commit;

  // Read view of every index; indices past NUM_REGS read as zero.
  logic [NUM_IDX-1:0][DATA_W-1:0] view;

`ifdef SLOT_IRQ_EN
  logic pending_reg;
  logic irq_n_reg;
`endif

  // The write lands on the edge that leaves ACK, which happens once per cycle.
  assign wr_commit = (state_reg == ST_ACK) && !rd_reg;

  // Handshake FSM. cnt_reg holds the number of not-ready cycles still owed,
  // counting the current one; the IDLE cycle with cs_n low already owes one,
  // so a single wait state goes straight to ACK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      rd_reg       <= 1'b0;
      data_out_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!cs_n) begin
            idx_reg <= addr;
            rd_reg  <= io_r_w_;
            cnt_reg <= wait_states;
            if (io_r_w_) data_out_reg <= view[addr];
            state_reg <= (wait_states > WAIT_W'(1)) ? ST_WAIT : ST_ACK;
          end
        end
        ST_WAIT: begin
          if (cs_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg - WAIT_W'(1);
            if (cnt_reg == WAIT_W'(2)) begin
              state_reg <= ST_ACK;
              if (rd_reg) data_out_reg <= view[idx_reg];
            end
          end
        end
        ST_ACK: begin
          state_reg <= ST_HOLD;
        end
        default: begin
          if (cs_n) state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Ready is combinational in IDLE so the first active edge already sees it.
  always_comb begin
    dev_ready_n = 1'b1;
    case (state_reg)
      ST_IDLE: dev_ready_n = rst | cs_n | (wait_states == '0);
      ST_WAIT: dev_ready_n = 1'b0;
      default: dev_ready_n = 1'b1;
    endcase
  end

  assign data_oe   = !cs_n && rd_reg && (state_reg != ST_IDLE);
  assign data_out  = data_out_reg;
  assign regs_flat = view[NUM_REGS-1:0];

  // Register file: one flop bank per live index, zero view for the rest.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IDX; gi++) begin : g_reg
      if (gi < NUM_REGS) begin : g_live
        logic [DATA_W-1:0] r_reg;

        // Commit the host write when this index was latched at cycle start.
        always_ff @(posedge clk or posedge rst) begin
          if (rst)                                       r_reg <= '0;
          else if (wr_commit && idx_reg == IDX_W'(gi))   r_reg <= data_in;
        end
`ifdef SLOT_IRQ_EN
        if (gi == NUM_REGS - 1) begin : g_irq
          assign view[gi] = {{(DATA_W-2){1'b0}}, r_reg[1], pending_reg};
        end else begin : g_plain
          assign view[gi] = r_reg;
        end
`else
        assign view[gi] = r_reg;
`endif
      end else begin : g_void
        assign view[gi] = '0;
      end
    end
  endgenerate

`ifdef SLOT_IRQ_EN
  // Sticky pending bit; a new set beats a same-edge clear from the host.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= 1'b0;
      irq_n_reg   <= 1'b1;
    end else begin
      if (irq_set)
        pending_reg <= 1'b1;
      else if (wr_commit && idx_reg == IDX_W'(NUM_REGS - 1) && data_in[0])
        pending_reg <= 1'b0;
      irq_n_reg <= ~(pending_reg & view[NUM_REGS-1][1]);
    end
  end

  assign irq_n = irq_n_reg;
`endif

endmodule

// File: tb/tb_slot_io_target.sv
// Directed testbench for slot_io_target (NUM_REGS=3 so index 3 is out of range).
// Build with SLOT_IRQ_EN defined to also exercise the IRQ control register.
module tb_slot_io_target;

  logic        clk;
  logic        rst;
  logic        cs_n;
  logic        io_r_w_;
  logic [1:0]  addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        dev_ready_n;
  logic [3:0]  wait_states;
  logic [23:0] regs_flat;
`ifdef SLOT_IRQ_EN
  logic        irq_set;
  logic        irq_n;
  // Register 2 is the IRQ control register: after writing A5 it shows
  // enable=0 and pending=0.
  localparam logic [7:0] REG2_A5 = 8'h00;
`else
  localparam logic [7:0] REG2_A5 = 8'hA5;
`endif

  int tests = 0;
  int fails = 0;

  slot_io_target #(
    .IDX_W(2), .NUM_REGS(3), .DATA_W(8), .WAIT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cs_n(cs_n),
    .io_r_w_(io_r_w_),
    .addr(addr),
    .data_in(data_in),
    .data_out(data_out),
    .data_oe(data_oe),
    .dev_ready_n(dev_ready_n),
    .wait_states(wait_states),
`ifdef SLOT_IRQ_EN
    .irq_set(irq_set),
    .irq_n(irq_n),
`endif
    .regs_flat(regs_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One full host cycle starting from IDLE; returns not-ready cycle count and
  // the data seen on the bus during ACK.
  task automatic bus_cycle(input logic rd, input logic [1:0] a, input logic [7:0] d,
                           input logic [3:0] ws, output int low_cnt, output logic [7:0] rdata);
    logic seen;
    cs_n = 1'b0; io_r_w_ = rd; addr = a; data_in = d; wait_states = ws;
    low_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      #1;
      if (dev_ready_n === 1'b1) seen = 1'b1;
      else begin
        low_cnt++;
        step();
      end
    end
    chk("ready_timeout", {31'd0, seen}, 32'd1);
    if (low_cnt == 0) step();      // zero-wait: IDLE -> ACK
    rdata = data_out;
    chk("oe_in_ack", {31'd0, data_oe}, {31'd0, rd});
    step();                        // ACK -> HOLD
    chk("hold_data", {24'd0, data_out}, {24'd0, rdata});
    cs_n = 1'b1;
    #1;
    chk("oe_off", {31'd0, data_oe}, 32'd0);
    step();                        // HOLD -> IDLE
    $display("[TB] cycle rd=%0b addr=%0d ws=%0d low=%0d data=%02h", rd, a, ws, low_cnt, rdata);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          low;
    logic [7:0]  rd;

    rst = 1'b1; cs_n = 1'b1; io_r_w_ = 1'b1; addr = '0; data_in = '0; wait_states = '0;
`ifdef SLOT_IRQ_EN
    irq_set = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready", {31'd0, dev_ready_n}, 32'd1);
    chk("rst_oe",    {31'd0, data_oe},     32'd0);
    chk("rst_regs",  {8'd0, regs_flat},    32'd0);
    chk("rst_dout",  {24'd0, data_out},    32'd0);
`ifdef SLOT_IRQ_EN
    chk("rst_irq_n", {31'd0, irq_n},       32'd1);
`endif
    rst = 1'b0;
    step();

    // Zero-wait write then read of register 2.
    bus_cycle(1'b0, 2'd2, 8'hA5, 4'd0, low, rd);
    chk("w2_low", low, 0);
    chk("w2_reg", {24'd0, regs_flat[23:16]}, {24'd0, REG2_A5});
    bus_cycle(1'b1, 2'd2, 8'h00, 4'd0, low, rd);
    chk("r2_low",  low, 0);
    chk("r2_data", {24'd0, rd}, {24'd0, REG2_A5});

    // Wait-state stretch on register 1.
    bus_cycle(1'b0, 2'd1, 8'h5A, 4'd0, low, rd);
    chk("w1_reg", {24'd0, regs_flat[15:8]}, 32'h5A);
    bus_cycle(1'b1, 2'd1, 8'h00, 4'd3, low, rd);
    chk("r1_ws3_low",  low, 3);
    chk("r1_ws3_data", {24'd0, rd}, 32'h5A);
    bus_cycle(1'b1, 2'd1, 8'h00, 4'd1, low, rd);
    chk("r1_ws1_low",  low, 1);
    chk("r1_ws1_data", {24'd0, rd}, 32'h5A);

    // Out-of-range index: read returns zero, write is dropped.
    bus_cycle(1'b1, 2'd3, 8'h00, 4'd2, low, rd);
    chk("oor_r_low",  low, 2);
    chk("oor_r_data", {24'd0, rd}, 32'h00);
    bus_cycle(1'b0, 2'd3, 8'h77, 4'd0, low, rd);
    chk("oor_w_regs", {8'd0, regs_flat}, {8'd0, REG2_A5, 8'h5A, 8'h00});

    // Aborted write to register 0.
    cs_n = 1'b0; io_r_w_ = 1'b0; addr = 2'd0; data_in = 8'hFF; wait_states = 4'd4;
    step();
    step();
    cs_n = 1'b1;
    step();
    chk("abort_ready", {31'd0, dev_ready_n}, 32'd1);
    chk("abort_oe",    {31'd0, data_oe},     32'd0);
    chk("abort_reg0",  {24'd0, regs_flat[7:0]}, 32'd0);
    step();
    bus_cycle(1'b1, 2'd0, 8'h00, 4'd0, low, rd);
    chk("abort_rd0", {24'd0, rd}, 32'd0);

    // Reset asserted during WAIT of a read of register 1.
    cs_n = 1'b0; io_r_w_ = 1'b1; addr = 2'd1; wait_states = 4'd5;
    step();
    step();
    chk("mid_ready_lo", {31'd0, dev_ready_n}, 32'd0);
    chk("mid_dout",     {24'd0, data_out},    32'h5A);
    chk("mid_oe",       {31'd0, data_oe},     32'd1);
    rst = 1'b1;
    #1;
    chk("mrst_ready", {31'd0, dev_ready_n}, 32'd1);
    chk("mrst_oe",    {31'd0, data_oe},     32'd0);
    chk("mrst_dout",  {24'd0, data_out},    32'd0);
    chk("mrst_regs",  {8'd0, regs_flat},    32'd0);
    cs_n = 1'b1;
    step();
    rst = 1'b0;
    step();

`ifdef SLOT_IRQ_EN
    // IRQ control register (index 2).
    irq_set = 1'b1;
    step();
    irq_set = 1'b0;
    bus_cycle(1'b0, 2'd2, 8'h02, 4'd0, low, rd);
    step();
    chk("irq_assert", {31'd0, irq_n}, 32'd0);
    bus_cycle(1'b1, 2'd2, 8'h00, 4'd0, low, rd);
    chk("irq_rd_pend", {24'd0, rd}, 32'h03);
    bus_cycle(1'b0, 2'd2, 8'h03, 4'd0, low, rd);
    step();
    chk("irq_clear", {31'd0, irq_n}, 32'd1);
    bus_cycle(1'b1, 2'd2, 8'h00, 4'd0, low, rd);
    chk("irq_rd_clr", {24'd0, rd}, 32'h02);
    irq_set = 1'b1;
    bus_cycle(1'b0, 2'd2, 8'h03, 4'd0, low, rd);
    irq_set = 1'b0;
    bus_cycle(1'b1, 2'd2, 8'h00, 4'd0, low, rd);
    chk("irq_set_wins", {24'd0, rd}, 32'h03);
    step();
    chk("irq_reassert", {31'd0, irq_n}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
